// File: rtl/mrv32_pkg.sv
// Shared constants and types for the mrv32 core.
// Memory geometry, reset vector and fetch-stage state encoding.
package mrv32_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int MEM_BYTES  = 1 << ADDR_WIDTH;
  localparam int RD_LATENCY = 2;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] align_pc(
    input logic [31:0] pc
  );
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear and occupancy count.
// Clear wins over push and pop issued in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage carries no reset; the count alone defines validity.
  always_ff @(posedge clk) begin
    if (w_push && !i_clr) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: credit-limited prefetch into a buffer,
// redirect flush, and dropping of responses to abandoned requests.
module instr_fetch
  import mrv32_pkg::*;
#(
  parameter int          ADDR_WIDTH = mrv32_pkg::ADDR_WIDTH,
  parameter logic [31:0] RESET_PC   = mrv32_pkg::RESET_PC,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  mem_valid,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_rvalid,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst_data,
  output logic [31:0]           inst_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_head_pc;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_drop;

  logic [CW-1:0] w_count;
  logic [31:0]   w_rdata;
  logic [31:0]   w_tgt;
  logic          w_full;
  logic          w_empty;
  logic          w_credit;
  logic          w_issue;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;
  logic          w_unused;

  assign w_tgt = align_pc(redirect_pc);

  // Stale in-flight requests still hold credit until they return.
  assign w_credit =
    (int'(r_out) + int'(w_count)) < FIFO_DEPTH;

  assign w_issue = (r_state == RUN) && fetch_en &&
                   !redirect_valid && w_credit;

  assign w_rsp  = mem_rvalid && (r_out != '0);
  assign w_push = w_rsp && (r_drop == '0) && !redirect_valid;
  assign w_pop  = !w_empty && inst_ready && !redirect_valid;

  assign mem_valid = w_issue;
  assign mem_addr  = r_fetch_pc[ADDR_WIDTH-1:0];
  assign mem_wdata = '0;
  assign mem_wstrb = '0;

  assign inst_valid = !w_empty;
  assign inst_data  = w_empty ? '0 : w_rdata;
  assign inst_pc    = r_head_pc;

  assign w_unused = ^{redirect_pc[1:0], r_fetch_pc, w_full};

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (redirect_valid),
    .i_push  (w_push),
    .i_wdata (mem_rdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_head_pc  <= RESET_PC;
      r_out      <= '0;
      r_drop     <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (fetch_en)  r_state <= RUN;
        RUN:  if (!fetch_en) r_state <= IDLE;
      endcase

      unique case ({w_issue, w_rsp})
        2'b10:   r_out <= r_out + CW'(1);
        2'b01:   r_out <= r_out - CW'(1);
        default: ;
      endcase

      // Everything still in flight at a redirect becomes stale.
      unique case (1'b1)
        redirect_valid: begin
          r_fetch_pc <= w_tgt;
          r_head_pc  <= w_tgt;
          r_drop     <= w_rsp ? r_out - CW'(1) : r_out;
        end
        default: begin
          if (w_issue)
            r_fetch_pc <= r_fetch_pc + 32'd4;
          if (w_pop)
            r_head_pc <= r_head_pc + 32'd4;
          if (w_rsp && (r_drop != '0))
            r_drop <= r_drop - CW'(1);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: fixed-latency memory, stream model
// of expected (pc, word) pairs, directed plus random phases.
module tb_instr_fetch;
  import mrv32_pkg::*;

  localparam int AW    = ADDR_WIDTH;
  localparam int DEPTH = 4;
  localparam int NW    = MEM_BYTES / 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_en;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          mem_valid;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic [31:0]   mem_rdata;
  logic          mem_rvalid;
  logic          inst_valid;
  logic          inst_ready;
  logic [31:0]   inst_data;
  logic [31:0]   inst_pc;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_valid      (mem_valid),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_wstrb      (mem_wstrb),
    .mem_rdata      (mem_rdata),
    .mem_rvalid     (mem_rvalid),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  // Memory: word array behind a RD_LATENCY-deep request pipe.
  logic [31:0]           mem_w [NW];
  logic [RD_LATENCY-1:0] pv = '0;
  logic [AW-1:0]         pa [RD_LATENCY];
  logic                  inj;

  always @(posedge clk) begin
    pv    <= {pv[RD_LATENCY-2:0], mem_valid};
    pa[0] <= mem_addr;
    for (int i = 1; i < RD_LATENCY; i++) pa[i] <= pa[i-1];
  end

  assign mem_rvalid = pv[RD_LATENCY-1] | inj;
  assign mem_rdata  = inj ? 32'hDEAD_BEEF
                          : mem_w[pa[RD_LATENCY-1][AW-1:2]];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          live;
  int          n_issue = 0;
  int          first_issue;
  int          first_valid;
  int          r_cyc;
  int          n0;
  bit          cap_pc;
  bit          cap_addr;
  logic [31:0] exp_pc;
  logic [31:0] exp_fetch;
  logic [31:0] first_pc;
  logic [31:0] first_addr;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc    = RESET_PC;
    exp_fetch = RESET_PC;
    live      = 0;
  endtask

  // One cycle: sample at negedge, update the stream model for
  // the coming edge, then return 1 time unit after that edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (redirect_valid)
      chk("redir_no_issue", 32'(mem_valid), 32'd0);
    chk("wstrb", 32'(mem_wstrb), 32'd0);
    if (mem_valid) begin
      chk("mem_addr", 32'(mem_addr), 32'(exp_fetch[AW-1:0]));
      if (cap_addr) begin
        first_addr = 32'(mem_addr);
        cap_addr = 0;
      end
      if (first_issue < 0) first_issue = cyc;
      exp_fetch += 32'd4;
      live++;
      n_issue++;
    end
    chk("credit", 32'(live <= DEPTH), 32'd1);
    if (inst_valid) begin
      if (first_valid < 0) first_valid = cyc;
      if (cap_pc) begin
        first_pc = inst_pc;
        cap_pc = 0;
      end
      chk("inst_pc", inst_pc, exp_pc);
      chk("inst_data", inst_data, mem_w[exp_pc[AW-1:2]]);
      if (inst_ready && !redirect_valid) begin
        exp_pc += 32'd4;
        live--;
      end
    end
    if (redirect_valid) begin
      exp_pc    = align_pc(redirect_pc);
      exp_fetch = exp_pc;
      live      = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic redir(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    r_cyc          = cyc + 1;
    tick();
    redirect_valid = 1'b0;
    cap_pc         = 1;
    cap_addr       = 1;
  endtask

  initial begin
    for (int i = 0; i < NW; i++) mem_w[i] = $urandom;
    rst_n = 0; fetch_en = 0; redirect_valid = 0;
    redirect_pc = 0; inst_ready = 1; inj = 0;
    cap_pc = 0; cap_addr = 0;
    first_pc = 0; first_addr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, RESET_PC);
    chk("rst_wdata", mem_wdata, 32'd0);

    // Sequential stream after reset release.
    first_issue = -1;
    first_valid = -1;
    fetch_en = 1;
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    run(20);
    chk("first_latency", 32'(first_valid - first_issue),
        32'(RD_LATENCY + 1));
    n0 = n_issue;
    run(20);
    chk("steady_issue", 32'(n_issue - n0), 32'd20);

    // Decode stall fills credit and stops requests.
    inst_ready = 0;
    run(20);
    chk("stall_live", 32'(live), 32'(DEPTH));
    chk("stall_mem_valid", 32'(mem_valid), 32'd0);
    chk("stall_inst_valid", 32'(inst_valid), 32'd1);
    inst_ready = 1;
    run(10);

    // Redirect from a drained, stalled pipeline.
    inst_ready = 0;
    run(12);
    redir(32'h0000_0080);
    chk("flush_empty", 32'(inst_valid), 32'd0);
    first_valid = -1;
    run(8);
    chk("redir_latency", 32'(first_valid - r_cyc),
        32'(RD_LATENCY + 2));
    inst_ready = 1;
    run(10);

    // Redirect with requests in flight.
    redir(32'h0000_0040);
    run(15);
    chk("redir40_pc", first_pc, 32'h0000_0040);

    redir(32'h0000_0043);
    run(15);
    chk("redir43_addr", first_addr, 32'h0000_0040);
    chk("redir43_pc", first_pc, 32'h0000_0040);

    // Redirect while a response lands and a pop happens.
    chk("coinc_setup", 32'(mem_rvalid && inst_valid), 32'd1);
    redir(32'h0000_0100);
    chk("coinc_flush", 32'(inst_valid), 32'd0);
    run(15);

    // Idle: no requests, redirect accepted, stray response.
    fetch_en = 0;
    run(2);
    n0 = n_issue;
    run(8);
    chk("idle_no_issue", 32'(n_issue - n0), 32'd0);
    redir(32'h0000_0200);
    chk("idle_redir_pc", inst_pc, 32'h0000_0200);
    chk("idle_redir_empty", 32'(inst_valid), 32'd0);
    inj = 1;
    tick();
    inj = 0;
    tick();
    chk("stray_rsp", 32'(inst_valid), 32'd0);
    fetch_en = 1;
    n0 = n_issue;
    run(12);
    chk("resume_issue", 32'(n_issue > n0), 32'd1);
    chk("resume_pc", first_pc, 32'h0000_0200);

    // PC wrap past 2^32.
    redir(32'hFFFF_FFF8);
    run(14);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      inst_ready     = ($urandom % 4) != 0;
      fetch_en       = ($urandom % 16) != 0;
      redirect_valid = ($urandom % 25) == 0;
      redirect_pc    = $urandom;
      tick();
    end
    redirect_valid = 0;
    fetch_en = 1;
    inst_ready = 1;
    run(10);

    // Reset in mid-stream.
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("mid_rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("mid_rst_inst_data", inst_data, 32'd0);
    chk("mid_rst_inst_pc", inst_pc, RESET_PC);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    cap_addr = 1;
    cap_pc = 1;
    @(posedge clk);
    #1;
    run(12);
    chk("restart_addr", first_addr, 32'(RESET_PC[AW-1:0]));
    chk("restart_pc", first_pc, RESET_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
